// File: rtl/pipelined_barrel_shifter.sv
// Pipelined log-shifter: levels WIDTH/2..1, optional register after each level, one output register.
// Define SHIFTER_FLAGS_EN to add registered out_zero/out_carry flags.
module pipelined_barrel_shifter #(
    parameter int                 WIDTH    = 32,
    parameter int                 SHAMT_W  = $clog2(WIDTH),
    parameter logic [SHAMT_W-1:0] REG_MASK = SHAMT_W'(5'b00100),
    parameter int                 TAG_W    = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [2:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_illegal
`ifdef SHIFTER_FLAGS_EN
    ,
    output logic               out_zero,
    output logic               out_carry
`endif
);

    typedef struct packed {
        logic               vld;
        logic               ill;
        logic               msb;
`ifdef SHIFTER_FLAGS_EN
        logic               cy;
`endif
        logic [2:0]         op;
        logic [TAG_W-1:0]   tag;
        logic [SHAMT_W-1:0] shamt;
        logic [WIDTH-1:0]   data;
    } stage_t;

    logic               ready_q;
    logic               advance;
    logic               out_valid_q;
    logic [WIDTH-1:0]   out_data_q;
    logic [TAG_W-1:0]   out_tag_q;
    logic               out_ill_q;
    stage_t             in_st;
    stage_t             fin;

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = ready_q && advance;

`ifdef SHIFTER_FLAGS_EN
    logic [SHAMT_W-1:0] cy_l_idx, cy_r_idx;
    assign cy_l_idx = SHAMT_W'(0) - in_shamt;
    assign cy_r_idx = in_shamt - 1'b1;
`endif

    always_comb begin
        in_st       = '0;
        in_st.vld   = in_valid && in_ready;
        in_st.ill   = in_op > 3'd4;
        in_st.msb   = in_data[WIDTH-1];
        in_st.op    = in_op;
        in_st.tag   = in_tag;
        in_st.shamt = in_shamt;
        in_st.data  = in_data;
`ifdef SHIFTER_FLAGS_EN
        // last bit shifted out, captured up front while the operand is intact
        in_st.cy    = (in_op == 3'b000) ? in_data[cy_l_idx] : in_data[cy_r_idx];
`endif
    end

    for (genvar i = 0; i < SHAMT_W; i++) begin : g_lvl
        localparam int SH = 1 << i;
        stage_t prev, st_d, st_o;

        if (i == SHAMT_W - 1) begin : g_src
            assign prev = in_st;
        end else begin : g_chain
            assign prev = g_lvl[i+1].st_o;
        end

        always_comb begin
            st_d = prev;
            if (prev.shamt[i]) begin
                case (prev.op)
                    3'b000:  st_d.data = {prev.data[WIDTH-1-SH:0], {SH{1'b0}}};
                    3'b001:  st_d.data = {{SH{1'b0}}, prev.data[WIDTH-1:SH]};
                    3'b010:  st_d.data = {{SH{prev.msb}}, prev.data[WIDTH-1:SH]};
                    3'b011:  st_d.data = {prev.data[WIDTH-1-SH:0], prev.data[WIDTH-1:WIDTH-SH]};
                    3'b100:  st_d.data = {prev.data[SH-1:0], prev.data[WIDTH-1:SH]};
                    default: st_d.data = prev.data;
                endcase
            end
        end

        if (REG_MASK[i]) begin : g_reg
            stage_t st_q;
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n)     st_q     <= '0;
                else if (flush)   st_q.vld <= 1'b0;
                else if (advance) st_q     <= st_d;
            end
            assign st_o = st_q;
        end else begin : g_comb
            assign st_o = st_d;
        end
    end

    assign fin = g_lvl[0].st_o;

`ifdef SHIFTER_FLAGS_EN
    logic out_zero_q, out_carry_q, carry_d;
    always_comb begin
        carry_d = 1'b0;
        if (fin.shamt != '0 && !fin.ill) begin
            case (fin.op)
                3'b011:  carry_d = fin.data[0];
                3'b100:  carry_d = fin.data[WIDTH-1];
                default: carry_d = fin.cy;
            endcase
        end
    end
    assign out_zero  = out_zero_q;
    assign out_carry = out_carry_q;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_ill_q   <= 1'b0;
`ifdef SHIFTER_FLAGS_EN
            out_zero_q  <= 1'b0;
            out_carry_q <= 1'b0;
`endif
        end else begin
            ready_q <= 1'b1;
            if (flush) begin
                out_valid_q <= 1'b0;
            end else if (advance) begin
                out_valid_q <= fin.vld;
                out_data_q  <= fin.data;
                out_tag_q   <= fin.tag;
                out_ill_q   <= fin.ill;
`ifdef SHIFTER_FLAGS_EN
                out_zero_q  <= (fin.data == '0);
                out_carry_q <= carry_d;
`endif
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ^{fin.msb, fin.op, fin.shamt};

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_tag     = out_tag_q;
    assign out_illegal = out_ill_q;

endmodule
